text_renderer: RTL

//  Parametrised text-mode pixel stage: takes per-pixel char code, cell row/col and RGB332 fg/bg

---
 rtl/textmode_pkg.sv | 29 ++
 rtl/text_renderer_if.sv | 37 +++
 rtl/rgb_expand.sv | 15 +
 rtl/text_renderer.sv | 111 +++++++++++
 4 files changed

// File: rtl/textmode_pkg.sv
// rtl/textmode_pkg.sv - shared types, pipeline latency and RGB332 channel expansion for the text renderer.
package textmode_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam int unsigned LAT = 3;

  // Result sits in the low chw bits: the field repeated MSB-first, truncated to chw bits.
  function automatic logic [31:0] expand(input logic [2:0] field, input int unsigned nbits,
                                         input int unsigned chw);
    logic [31:0] v;
    logic [1:0]  src;
    logic [4:0]  dst;
    v = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < chw) begin
        src    = 2'(nbits - 1 - (i % nbits));
        dst    = 5'(chw - 1 - i);
        v[dst] = field[src];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/text_renderer_if.sv
// rtl/text_renderer_if.sv - pixel-in, font ROM and pixel-out signals of the text renderer.
interface text_renderer_if #(
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 16,
  parameter int unsigned CH_W    = 8
);
  localparam int unsigned ROW_W = $clog2(GLYPH_H);
  localparam int unsigned COL_W = $clog2(GLYPH_W);

  logic                    i_hs;
  logic                    i_vs;
  logic                    i_von;
  logic [CHAR_W-1:0]       i_char;
  logic [ROW_W-1:0]        i_row;
  logic [COL_W-1:0]        i_col;
  logic [7:0]              i_fg;
  logic [7:0]              i_bg;
  logic                    i_blink;
  logic [CHAR_W+ROW_W-1:0] o_font_addr;
  logic [GLYPH_W-1:0]      i_font_data;
  logic                    o_hs;
  logic                    o_vs;
  logic [CH_W-1:0]         o_r;
  logic [CH_W-1:0]         o_g;
  logic [CH_W-1:0]         o_b;

  modport master (
    output i_hs, i_vs, i_von, i_char, i_row, i_col, i_fg, i_bg, i_blink, i_font_data,
    input  o_font_addr, o_hs, o_vs, o_r, o_g, o_b
  );

  modport slave (
    input  i_hs, i_vs, i_von, i_char, i_row, i_col, i_fg, i_bg, i_blink, i_font_data,
    output o_font_addr, o_hs, o_vs, o_r, o_g, o_b
  );
endinterface

// File: rtl/rgb_expand.sv
// rtl/rgb_expand.sv - combinational RGB332 to 3 x CH_W channel expansion.
module rgb_expand
  import textmode_pkg::*;
#(
  parameter int unsigned CH_W = 8
) (
  input  rgb332_t         i_rgb,
  output logic [CH_W-1:0] o_r,
  output logic [CH_W-1:0] o_g,
  output logic [CH_W-1:0] o_b
);
  assign o_r = CH_W'(expand(i_rgb.r, 3, CH_W));
  assign o_g = CH_W'(expand(i_rgb.g, 3, CH_W));
  assign o_b = CH_W'(expand({1'b0, i_rgb.b}, 2, CH_W));
endmodule

// File: rtl/text_renderer.sv
// rtl/text_renderer.sv - 3-stage text-mode pixel pipeline: font fetch, fg/bg select, RGB expand.
// Optional attribute blink is enabled by defining TEXT_BLINK_EN.
module text_renderer
  import textmode_pkg::*;
#(
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned GLYPH_W     = 8,
  parameter int unsigned GLYPH_H     = 16,
  parameter int unsigned CH_W        = 8,
  parameter int unsigned BLINK_SHIFT = 4
) (
  input logic            i_clk,
  input logic            i_reset,
  text_renderer_if.slave bus
);
  localparam int unsigned ROW_W = $clog2(GLYPH_H);
  localparam int unsigned COL_W = $clog2(GLYPH_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(GLYPH_W - 1);

  logic [CHAR_W+ROW_W-1:0] r_font_addr;
  logic [COL_W-1:0]        r_col1, r_col2;
  rgb332_t                 r_fg1, r_fg2, r_bg1, r_bg2;
  logic                    r_von1, r_von2;
  logic [LAT-1:0]          r_hs_dly, r_vs_dly;
  logic [CH_W-1:0]         r_r, r_g, r_b;

  logic [COL_W-1:0] w_bit_idx;
  logic             w_bit;
  logic             w_use_fg;
  rgb332_t          w_pix;
  logic [CH_W-1:0]  w_r, w_g, w_b;

  assign w_bit_idx = LAST_COL - r_col2;
  assign w_bit     = bus.i_font_data[w_bit_idx];

`ifdef TEXT_BLINK_EN
  logic                 r_blink1, r_blink2;
  logic [BLINK_SHIFT:0] r_frame_cnt;

  // Blinking cells show background during the odd half of the blink period.
  assign w_use_fg = w_bit & ~(r_blink2 & r_frame_cnt[BLINK_SHIFT]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blink1    <= 1'b0;
      r_blink2    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_blink1 <= bus.i_blink;
      r_blink2 <= r_blink1;
      if (r_vs_dly[1] & ~r_vs_dly[0])
        r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end
`else
  logic w_unused_blink;

  assign w_unused_blink = ^{bus.i_blink, 1'(BLINK_SHIFT)};
  assign w_use_fg       = w_bit;
`endif

  assign w_pix = w_use_fg ? r_fg2 : r_bg2;

  rgb_expand #(.CH_W(CH_W)) u_expand (
    .i_rgb (w_pix),
    .o_r   (w_r),
    .o_g   (w_g),
    .o_b   (w_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_font_addr <= '0;
      r_col1      <= '0;
      r_col2      <= '0;
      r_fg1       <= '0;
      r_fg2       <= '0;
      r_bg1       <= '0;
      r_bg2       <= '0;
      r_von1      <= 1'b0;
      r_von2      <= 1'b0;
      r_hs_dly    <= '1;
      r_vs_dly    <= '1;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
    end else begin
      r_font_addr <= {bus.i_char, bus.i_row};
      r_col1      <= bus.i_col;
      r_col2      <= r_col1;
      r_fg1       <= bus.i_fg;
      r_fg2       <= r_fg1;
      r_bg1       <= bus.i_bg;
      r_bg2       <= r_bg1;
      r_von1      <= bus.i_von;
      r_von2      <= r_von1;
      r_hs_dly    <= {r_hs_dly[LAT-2:0], bus.i_hs};
      r_vs_dly    <= {r_vs_dly[LAT-2:0], bus.i_vs};
      r_r         <= r_von2 ? w_r : '0;
      r_g         <= r_von2 ? w_g : '0;
      r_b         <= r_von2 ? w_b : '0;
    end
  end

  assign bus.o_font_addr = r_font_addr;
  assign bus.o_hs        = r_hs_dly[LAT-1];
  assign bus.o_vs        = r_vs_dly[LAT-1];
  assign bus.o_r         = r_r;
  assign bus.o_g         = r_g;
  assign bus.o_b         = r_b;
endmodule
